// File: rtl/vram_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vram_port_arbiter_if: Avalon slave, renderer fetch and VRAM port bundle. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface vram_port_arbiter_if;
  logic        AVL_READ;
  logic        AVL_WRITE;
  logic        AVL_CS;
  logic [3:0]  AVL_BYTE_EN;
  logic [11:0] AVL_ADDR;
  logic [31:0] AVL_WRITEDATA;
  logic [31:0] AVL_READDATA;
  logic        AVL_WAITREQUEST;
  logic        VID_REQ;
  logic [9:0]  VID_ADDR;
  logic        VID_ACK;
  logic        VID_RVALID;
  logic [31:0] VID_RDATA;
  logic [9:0]  MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [3:0]  MEM_BE;
  logic        MEM_WE;
  logic [31:0] MEM_RDATA;

  modport slave (
    input  AVL_READ, AVL_WRITE, AVL_CS, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
    output AVL_READDATA, AVL_WAITREQUEST,
    input  VID_REQ, VID_ADDR,
    output VID_ACK, VID_RVALID, VID_RDATA,
    output MEM_ADDR, MEM_WDATA, MEM_BE, MEM_WE,
    input  MEM_RDATA
  );

  modport master (
    output AVL_READ, AVL_WRITE, AVL_CS, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
    input  AVL_READDATA, AVL_WAITREQUEST,
    output VID_REQ, VID_ADDR,
    input  VID_ACK, VID_RVALID, VID_RDATA,
    input  MEM_ADDR, MEM_WDATA, MEM_BE, MEM_WE,
    output MEM_RDATA
  );
endinterface
`default_nettype wire

// File: rtl/vram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vram_port_arbiter: shares the text VRAM between CPU and renderer fetch.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vram_port_arbiter #(
  parameter int          VRAM_WORDS = 600,
  parameter logic [11:0] CTRL_ADDR  = 12'h258,
  parameter int          STARVE_MAX = 4
) (
  input  wire logic          CLK,
  input  wire logic          RESET_N,
  vram_port_arbiter_if.slave bus,
  output logic [31:0]        CTRL_REG
);

  localparam int              c_SW         = $clog2(STARVE_MAX + 1);
  localparam logic [11:0]     c_VRAM_LIMIT = 12'(VRAM_WORDS);
  localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_MAX);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_CPU_RD = 1'b1
  } state_t;

  state_t          r_state;
  logic [c_SW-1:0] r_starve;
  logic            r_vid_rvalid;
  logic [31:0]     r_ctrl;

  logic        w_cpu_req;
  logic        w_cpu_wr;
  logic        w_is_ctrl;
  logic        w_is_vram;
  logic        w_starved;
  logic        w_vid_grant;
  logic        w_cpu_grant;
  logic        w_wait;
  logic        w_ctrl_wr;
  logic        w_mem_we;
  logic [31:0] w_rdata;

  assign w_cpu_req = bus.AVL_CS & (bus.AVL_READ | bus.AVL_WRITE);
  assign w_cpu_wr  = bus.AVL_WRITE;
  assign w_is_ctrl = (bus.AVL_ADDR == CTRL_ADDR);
  assign w_is_vram = (bus.AVL_ADDR < c_VRAM_LIMIT) && !w_is_ctrl;
  assign w_starved = (r_starve == c_STARVE_MAX);

  // CPU_RD returns read data while leaving the VRAM port free for video.
  always_comb begin
    w_vid_grant = 1'b0;
    w_cpu_grant = 1'b0;
    w_wait      = 1'b1;
    w_ctrl_wr   = 1'b0;
    w_rdata     = '0;
    if (r_state == S_CPU_RD) begin
      w_wait      = 1'b0;
      w_rdata     = bus.MEM_RDATA;
      w_vid_grant = bus.VID_REQ;
    end else if (w_cpu_req && !w_is_vram) begin
      w_wait      = 1'b0;
      w_vid_grant = bus.VID_REQ;
      w_ctrl_wr   = w_cpu_wr && w_is_ctrl;
      if (!w_cpu_wr && w_is_ctrl) begin
        w_rdata = r_ctrl;
      end
    end else if (bus.VID_REQ && !(w_cpu_req && w_starved)) begin
      w_vid_grant = 1'b1;
    end else if (w_cpu_req) begin
      w_cpu_grant = 1'b1;
      w_wait      = !w_cpu_wr;
    end
  end

  assign w_mem_we            = RESET_N & w_cpu_grant & w_cpu_wr;
  assign bus.MEM_WE          = w_mem_we;
  assign bus.MEM_BE          = w_mem_we ? bus.AVL_BYTE_EN : 4'b0000;
  assign bus.MEM_WDATA       = bus.AVL_WRITEDATA;
  assign bus.MEM_ADDR        = w_cpu_grant ? bus.AVL_ADDR[9:0] :
                               (w_vid_grant ? bus.VID_ADDR : 10'd0);
  assign bus.VID_ACK         = RESET_N & w_vid_grant;
  assign bus.VID_RVALID      = r_vid_rvalid;
  assign bus.VID_RDATA       = bus.MEM_RDATA;
  assign bus.AVL_READDATA    = RESET_N ? w_rdata : 32'd0;
  assign bus.AVL_WAITREQUEST = !RESET_N | w_wait;
  assign CTRL_REG            = r_ctrl;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= S_IDLE;
      r_starve     <= '0;
      r_vid_rvalid <= 1'b0;
      r_ctrl       <= '0;
    end else begin
      r_vid_rvalid <= w_vid_grant;
      if (w_ctrl_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.AVL_BYTE_EN[b]) begin
            r_ctrl[8*b +: 8] <= bus.AVL_WRITEDATA[8*b +: 8];
          end
        end
      end
      case (r_state)
        S_IDLE: begin
          if (w_cpu_grant && !w_cpu_wr) begin
            r_state <= S_CPU_RD;
          end
          // Only a VRAM access losing to video counts toward starvation.
          if (w_cpu_req && w_is_vram && w_vid_grant) begin
            if (!w_starved) begin
              r_starve <= r_starve + c_SW'(1);
            end
          end else begin
            r_starve <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vram_port_arbiter: directed and random checks against a VRAM model.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_vram_port_arbiter;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ctrl_reg;
  int          n_checks = 0;
  int          n_fail = 0;

  vram_port_arbiter_if bus ();

  vram_port_arbiter dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus),
    .CTRL_REG(ctrl_reg)
  );

  always #10 clk = ~clk;

  // VRAM macro: byte-enabled write, one-cycle registered read.
  logic [31:0] vram [0:1023] = '{default: '0};
  logic [31:0] vram_q = '0;
  assign bus.MEM_RDATA = vram_q;
  always @(posedge clk) begin
    if (bus.MEM_WE) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.MEM_BE[b]) vram[bus.MEM_ADDR][8*b +: 8] <= bus.MEM_WDATA[8*b +: 8];
      end
    end
    vram_q <= vram[bus.MEM_ADDR];
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (nw & m);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_shadow [0:1023] = '{default: '0};
  logic [31:0] m_ctrl = '0;
  logic [31:0] m_rd_val = '0;
  logic [31:0] m_vid_val = '0;
  logic        m_rd_due = 1'b0;
  logic        m_vid_due = 1'b0;
  logic        m_cpu_done = 1'b0;
  logic        m_vid_ack = 1'b0;
  int          m_streak = 0;

  logic        creq, inv, e_wait, e_ack, e_we, e_grant, e_done, e_rdgrant, e_step;
  logic [3:0]  e_be;
  logic [9:0]  e_addr;
  logic [11:0] ca;
  logic [31:0] e_rdata, ctrl_next;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_wait", {31'd0, bus.AVL_WAITREQUEST}, 32'd1);
      chk("rst_rdata", bus.AVL_READDATA, 32'd0);
      chk("rst_ack", {31'd0, bus.VID_ACK}, 32'd0);
      chk("rst_we", {31'd0, bus.MEM_WE}, 32'd0);
      chk("rst_be", {28'd0, bus.MEM_BE}, 32'd0);
      chk("rst_rvalid", {31'd0, bus.VID_RVALID}, 32'd0);
      chk("rst_ctrl", ctrl_reg, 32'd0);
      m_ctrl = '0; m_streak = 0; m_rd_due = 0; m_vid_due = 0;
      m_cpu_done = 0; m_vid_ack = 0;
    end else begin
      creq = bus.AVL_CS && (bus.AVL_READ || bus.AVL_WRITE);
      ca = bus.AVL_ADDR;
      inv = (int'(ca) < 600) && (ca != 12'h258);
      e_wait = 1; e_rdata = '0; e_ack = 0; e_we = 0; e_be = '0; e_grant = 0;
      e_addr = '0; e_done = 0; e_rdgrant = 0; ctrl_next = m_ctrl;
      if (m_rd_due) begin
        e_wait = 0; e_rdata = m_rd_val; e_ack = bus.VID_REQ; e_done = 1;
      end else if (creq && !inv) begin
        e_wait = 0; e_done = 1; e_ack = bus.VID_REQ;
        if (ca == 12'h258) begin
          if (bus.AVL_WRITE) ctrl_next = merge(m_ctrl, bus.AVL_WRITEDATA, bus.AVL_BYTE_EN);
          else e_rdata = m_ctrl;
        end
      end else if (bus.VID_REQ && !(creq && m_streak >= STARVE)) begin
        e_ack = 1;
      end else if (creq) begin
        e_grant = 1; e_addr = ca[9:0];
        if (bus.AVL_WRITE) begin
          e_we = 1; e_be = bus.AVL_BYTE_EN; e_wait = 0; e_done = 1;
        end else begin
          e_rdgrant = 1;
        end
      end
      if (e_ack) e_addr = bus.VID_ADDR;
      e_step = !m_rd_due && creq && inv && e_ack;

      chk("wait", {31'd0, bus.AVL_WAITREQUEST}, {31'd0, e_wait});
      chk("rdata", bus.AVL_READDATA, e_rdata);
      chk("vid_ack", {31'd0, bus.VID_ACK}, {31'd0, e_ack});
      chk("mem_we", {31'd0, bus.MEM_WE}, {31'd0, e_we});
      chk("mem_be", {28'd0, bus.MEM_BE}, {28'd0, e_be});
      chk("vid_rvalid", {31'd0, bus.VID_RVALID}, {31'd0, m_vid_due});
      chk("ctrl", ctrl_reg, m_ctrl);
      if (m_vid_due) chk("vid_rdata", bus.VID_RDATA, m_vid_val);
      if (e_we) chk("mem_wdata", bus.MEM_WDATA, bus.AVL_WRITEDATA);
      if (e_ack || e_grant) chk("mem_addr", {22'd0, bus.MEM_ADDR}, {22'd0, e_addr});

      if (e_we) m_shadow[ca[9:0]] = merge(m_shadow[ca[9:0]], bus.AVL_WRITEDATA, bus.AVL_BYTE_EN);
      if (e_ack) m_vid_val = m_shadow[bus.VID_ADDR];
      m_vid_due = e_ack;
      if (e_rdgrant) m_rd_val = m_shadow[ca[9:0]];
      m_rd_due = e_rdgrant;
      m_streak = e_step ? m_streak + 1 : 0;
      m_ctrl = ctrl_next;
      m_cpu_done = e_done;
      m_vid_ack = e_ack;
    end
  end

  task automatic issue(input logic wr, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] rd, output int cyc,
                       output int acks, output logic we_d, output logic [3:0] be_d,
                       output logic ack_d);
    logic done;
    done = 0; rd = '0; cyc = 0; acks = 0; we_d = 0; be_d = '0; ack_d = 0;
    @(posedge clk); #1;
    bus.AVL_CS = 1; bus.AVL_READ = !wr; bus.AVL_WRITE = wr;
    bus.AVL_ADDR = a; bus.AVL_WRITEDATA = d; bus.AVL_BYTE_EN = be;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk); #1;
      if (!bus.AVL_WAITREQUEST) begin
        done = 1; rd = bus.AVL_READDATA; we_d = bus.MEM_WE;
        be_d = bus.MEM_BE; ack_d = bus.VID_ACK;
      end else begin
        cyc++;
        if (bus.VID_ACK) acks++;
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout: addr %h still waiting after %0d cycles", a, cyc);
    end
    @(posedge clk); #1;
    bus.AVL_CS = 0; bus.AVL_READ = 0; bus.AVL_WRITE = 0;
  endtask

  logic [31:0] rd;
  int          cyc, acks;
  logic        we_d, ack_d, cpu_active;
  logic [3:0]  be_d;
  int          op;

  initial begin
    bus.AVL_CS = 0; bus.AVL_READ = 0; bus.AVL_WRITE = 0; bus.AVL_BYTE_EN = '0;
    bus.AVL_ADDR = '0; bus.AVL_WRITEDATA = '0; bus.VID_REQ = 0; bus.VID_ADDR = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk); #1;
    chk("idle_wait", {31'd0, bus.AVL_WAITREQUEST}, 32'd1);
    chk("idle_ctrl", ctrl_reg, 32'd0);

    issue(1, 12'd5, 32'hDEADBEEF, 4'hF, rd, cyc, acks, we_d, be_d, ack_d);
    chk("wr5_latency", cyc, 0);
    chk("wr5_we", {31'd0, we_d}, 32'd1);
    issue(0, 12'd5, 32'd0, 4'hF, rd, cyc, acks, we_d, be_d, ack_d);
    chk("rd5_data", rd, 32'hDEADBEEF);
    chk("rd5_latency", cyc, 1);
    issue(1, 12'd5, 32'h11223344, 4'b0100, rd, cyc, acks, we_d, be_d, ack_d);
    chk("be_wr_be", {28'd0, be_d}, 32'h4);
    issue(0, 12'd5, 32'd0, 4'hF, rd, cyc, acks, we_d, be_d, ack_d);
    chk("be_rd_data", rd, 32'hDE22BEEF);
    issue(1, 12'd3, 32'hCAFE0003, 4'hF, rd, cyc, acks, we_d, be_d, ack_d);

    bus.VID_REQ = 1; bus.VID_ADDR = 10'd10;
    issue(0, 12'd3, 32'd0, 4'hF, rd, cyc, acks, we_d, be_d, ack_d);
    chk("starve_acks", acks, 4);
    chk("starve_latency", cyc, 5);
    chk("starve_data", rd, 32'hCAFE0003);
    chk("starve_rd_ack", {31'd0, ack_d}, 32'd1);

    issue(1, 12'h258, 32'h01E00000, 4'hF, rd, cyc, acks, we_d, be_d, ack_d);
    chk("ctrl_wr_latency", cyc, 0);
    chk("ctrl_wr_ack", {31'd0, ack_d}, 32'd1);
    @(negedge clk); #1;
    chk("ctrl_value", ctrl_reg, 32'h01E00000);
    @(posedge clk); #1;
    bus.VID_REQ = 0;

    issue(0, 12'h300, 32'd0, 4'hF, rd, cyc, acks, we_d, be_d, ack_d);
    chk("oor_rd_data", rd, 32'd0);
    chk("oor_rd_latency", cyc, 0);
    chk("oor_rd_we", {31'd0, we_d}, 32'd0);
    issue(1, 12'h300, 32'h55AA55AA, 4'hF, rd, cyc, acks, we_d, be_d, ack_d);
    chk("oor_wr_we", {31'd0, we_d}, 32'd0);
    issue(0, 12'h258, 32'd0, 4'hF, rd, cyc, acks, we_d, be_d, ack_d);
    chk("ctrl_rd_data", rd, 32'h01E00000);

    // Abandon a read in its data cycle.
    @(posedge clk); #1;
    bus.AVL_CS = 1; bus.AVL_READ = 1; bus.AVL_WRITE = 0; bus.AVL_ADDR = 12'd5;
    @(posedge clk); #1;
    rst_n = 0; bus.VID_REQ = 1;
    #1;
    chk("midrd_wait", {31'd0, bus.AVL_WAITREQUEST}, 32'd1);
    chk("midrd_ctrl", ctrl_reg, 32'd0);
    chk("midrd_rvalid", {31'd0, bus.VID_RVALID}, 32'd0);
    bus.AVL_CS = 0; bus.AVL_READ = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk); #1;
    chk("post_rst_rvalid", {31'd0, bus.VID_RVALID}, 32'd0);
    @(posedge clk); #1;
    bus.VID_REQ = 0;
    issue(0, 12'd5, 32'd0, 4'hF, rd, cyc, acks, we_d, be_d, ack_d);
    chk("post_rst_data", rd, 32'hDE22BEEF);
    chk("post_rst_latency", cyc, 1);

    cpu_active = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 499) != 0);
      if (!cpu_active || m_cpu_done) begin
        bus.AVL_WRITEDATA = $urandom;
        bus.AVL_BYTE_EN = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 9))
          0: bus.AVL_ADDR = 12'h258;
          1: bus.AVL_ADDR = 12'(600 + $urandom_range(0, 3495));
          2: bus.AVL_ADDR = 12'(595 + $urandom_range(0, 4));
          default: bus.AVL_ADDR = 12'($urandom_range(0, 15));
        endcase
        if ($urandom_range(0, 9) < 6) begin
          op = $urandom_range(0, 2);
          bus.AVL_CS = 1; bus.AVL_READ = (op != 1); bus.AVL_WRITE = (op != 0);
        end else begin
          bus.AVL_CS = 1'($urandom_range(0, 1));
          bus.AVL_READ = bus.AVL_CS ? 1'b0 : 1'($urandom_range(0, 1));
          bus.AVL_WRITE = bus.AVL_CS ? 1'b0 : 1'($urandom_range(0, 1));
        end
        cpu_active = bus.AVL_CS && (bus.AVL_READ || bus.AVL_WRITE);
      end
      if (!bus.VID_REQ || m_vid_ack) begin
        bus.VID_REQ = 1'($urandom_range(0, 1));
        bus.VID_ADDR = 10'($urandom_range(0, 15));
      end
    end

    @(posedge clk); #1;
    rst_n = 1; bus.AVL_CS = 0; bus.AVL_READ = 0; bus.AVL_WRITE = 0; bus.VID_REQ = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares the single-port 600-word text VRAM between two requesters: the Avalon-MM slave (CPU) and the text renderer's character-word fetch.
- Owns the 32-bit colour/control register at word address 0x258.
- Video fetch has priority; a starvation guard guarantees the CPU bounded latency.
- Sits between the Avalon slave port and the VRAM macro, inside the VGA text controller.

Parameters:
- VRAM_WORDS, 600: number of VRAM words; valid VRAM addresses are 0..VRAM_WORDS-1.
- CTRL_ADDR, 12'h258: word address of the control register.
- STARVE_MAX, 4: maximum consecutive video grants while a CPU access is pending.

Ports:
- CLK  in  1  system clock, 50 MHz
- RESET_N  in  1  reset, asynchronous, active-low
- AVL_READ  in  1  Avalon read
- AVL_WRITE  in  1  Avalon write
- AVL_CS  in  1  Avalon chip select
- AVL_BYTE_EN  in  4  Avalon byte enables
- AVL_ADDR  in  12  Avalon word address
- AVL_WRITEDATA  in  32  Avalon write data
- AVL_READDATA  out  32  Avalon read data
- AVL_WAITREQUEST  out  1  Avalon wait request
- VID_REQ  in  1  renderer fetch request, held until acknowledged
- VID_ADDR  in  10  renderer VRAM word address
- VID_ACK  out  1  fetch granted this cycle
- VID_RVALID  out  1  VID_RDATA valid
- VID_RDATA  out  32  fetched word
- CTRL_REG  out  32  control register (FGD/BKG colours) to the pixel path
- MEM_ADDR  out  10  VRAM address
- MEM_WDATA  out  32  VRAM write data
- MEM_BE  out  4  VRAM byte enables
- MEM_WE  out  1  VRAM write enable
- MEM_RDATA  in  32  VRAM read data, 1-cycle latency

Behaviour:
- CPU request definition: cpu_req = AVL_CS & (AVL_READ | AVL_WRITE).
  - If AVL_READ and AVL_WRITE are both high, the access is a write.
- Reset (RESET_N low, asynchronous):
  - State to IDLE, starve counter to 0, CTRL_REG to 0, VID_RVALID to 0.
  - VID_ACK, MEM_WE and MEM_BE to 0; AVL_READDATA to 0; AVL_WAITREQUEST to 1.
- States: IDLE, CPU_RD.
- IDLE, arbitration each cycle, evaluated in this order:
  1. cpu_req with address not a VRAM address, i.e. CTRL_ADDR or out of range. Completes in the same cycle with AVL_WAITREQUEST=0 and no VRAM port use.
     - Write to CTRL_ADDR: updates CTRL_REG per byte enable at that edge.
     - Read of CTRL_ADDR: AVL_READDATA=CTRL_REG.
     - Out-of-range write: dropped. Out-of-range read: returns 0.
     - Video is served in parallel in the same cycle if VID_REQ is high.
  2. VID_REQ and not (cpu_req and starve==STARVE_MAX): video grant.
     - VID_ACK=1, MEM_ADDR=VID_ADDR, MEM_WE=0.
     - starve increments (saturating at STARVE_MAX) if cpu_req, else clears to 0.
  3. cpu_req: CPU grant; MEM_ADDR=AVL_ADDR[9:0]; starve clears to 0.
     - Write: MEM_WE=1, MEM_BE=AVL_BYTE_EN, MEM_WDATA=AVL_WRITEDATA, AVL_WAITREQUEST=0 this cycle. BYTE_EN=0 still completes with no data change.
     - Read: MEM_WE=0; go to CPU_RD; AVL_WAITREQUEST stays 1.
  4. Otherwise: MEM_WE=0, AVL_WAITREQUEST=1 while cpu_req.
- CPU_RD, exactly one cycle:
  - AVL_READDATA=MEM_RDATA, AVL_WAITREQUEST=0, then return to IDLE.
  - The VRAM port is free in this cycle: a pending VID_REQ is granted, and that grant's data returns next cycle.
  - A CPU request in this cycle is the completing read, not a new one.
- Video return path:
  - VID_RVALID is registered: high exactly one cycle after each VID_ACK.
  - VID_RDATA=MEM_RDATA, valid only while VID_RVALID=1.
- Latencies:
  - VRAM read: 2 cycles minimum.
  - VRAM write: 1 cycle minimum.
  - Worst case under continuous VID_REQ: STARVE_MAX extra cycles.
- Reset mid-read: CPU_RD is abandoned and no VID_RVALID is produced after reset. The master must reissue.
- MEM outputs are combinational from the state and inputs. CTRL_REG and VID_RVALID are registered.

Test Plan:
- Reset, then CPU write addr 5, data 0xDEADBEEF, BE=4'hF, VID_REQ=0 → MEM_WE=1 and WAITREQUEST=0 in the same cycle. A read of addr 5 then returns 0xDEADBEEF with WAITREQUEST=0 exactly 1 cycle after issue.
- Byte-enable write of 0x11223344 with BE=4'b0100 over 0xDEADBEEF → MEM_BE=4'b0100. A subsequent read returns 0xDE22BEEF, given a VRAM model honouring BE.
- VID_REQ held high continuously with VID_ADDR=10 while the CPU reads addr 3 → exactly 4 VID_ACK cycles, then a CPU grant, then read data; VID_RVALID follows each ACK by 1 cycle.
- CPU write of 0x01E00000 to 0x258 while VID_REQ=1 → CTRL_REG=0x01E00000 next cycle, WAITREQUEST=0 in the issuing cycle, VID_ACK=1 in the same cycle.
- Read of addr 0x300 → AVL_READDATA=0, WAITREQUEST=0 same cycle, MEM_WE=0. Write to 0x300 → no VRAM write.
- Assert RESET_N=0 in the CPU_RD cycle → CTRL_REG=0, AVL_WAITREQUEST=1, VID_RVALID=0 immediately. After release the state is IDLE and the next read completes normally.
